// File: rtl/rk_pkg.sv
// Shared types and constants for the RK power-of-two scaler.
package rk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } rk_shift_state_t;

    localparam int RK_N   = 32;
    localparam int RK_SHW = 5;

    localparam logic [RK_N-1:0] RK_MAX = {1'b0, {(RK_N-1){1'b1}}};
    localparam logic [RK_N-1:0] RK_MIN = {1'b1, {(RK_N-1){1'b0}}};

endpackage

// File: rtl/signed_shifter.sv
// One-bit shifter: sel=0 shifts left inserting dbit at the LSB, sel=1 shifts right inserting dbit at the MSB.
module signed_shifter #(
    parameter int n = 32
) (
    input  logic [n-1:0] data_in,
    input  logic         dbit,
    input  logic         sel,
    output logic [n-1:0] data_out
);

    assign data_out = sel ? {dbit, data_in[n-1:1]} : {data_in[n-2:0], dbit};

endmodule

// File: rtl/rk_shift_seq.sv
// Multi-cycle x2^k / /2^k scaler built on a one-bit shifter.
// Optional build macro RK_SHIFT_SAT_EN: saturate the result on left-shift overflow.
module rk_shift_seq
    import rk_pkg::*;
#(
    parameter int N   = RK_N,
    parameter int SHW = RK_SHW
) (
    input  logic           clk,
    input  logic           clr_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_data,
    input  logic [SHW-1:0] in_amt,
    input  logic           in_dir,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic           out_ovf,
    output logic           busy
);

`ifdef RK_SHIFT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    rk_shift_state_t state_q, state_d;
    logic [N-1:0]    acc_q, acc_d, res_q, res_d, sh_out, result;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            dir_q, dir_d, ovf_q, ovf_d, sign0_q, sign0_d;
    logic            vld_q, vld_d, oovf_q, oovf_d, dbit;

    // Right shifts replicate the sign bit so the result floors toward -inf.
    assign dbit = dir_q ? acc_q[N-1] : 1'b0;

    signed_shifter #(.n(N)) u_shifter (
        .data_in  (acc_q),
        .dbit     (dbit),
        .sel      (dir_q),
        .data_out (sh_out)
    );

    assign result = (SAT_EN && ovf_q) ? (sign0_q ? SAT_MIN : SAT_MAX) : acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        ovf_d   = ovf_q;
        sign0_d = sign0_q;
        vld_d   = vld_q;
        oovf_d  = oovf_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = in_amt;
                    dir_d   = in_dir;
                    ovf_d   = 1'b0;
                    sign0_d = in_data[N-1];
                    state_d = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                acc_d = sh_out;
                cnt_d = cnt_q - SHW'(1);
                if (!dir_q && (acc_q[N-1] != acc_q[N-2])) ovf_d = 1'b1;
                if (cnt_q == SHW'(1)) state_d = DONE;
            end
            DONE: begin
                // First DONE cycle registers the result; it is then held until taken.
                if (!vld_q) begin
                    vld_d  = 1'b1;
                    res_d  = result;
                    oovf_d = ovf_q;
                end else if (out_ready) begin
                    vld_d   = 1'b0;
                    oovf_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            ovf_q   <= 1'b0;
            sign0_q <= 1'b0;
            vld_q   <= 1'b0;
            oovf_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ovf_q   <= ovf_d;
            sign0_q <= sign0_d;
            vld_q   <= vld_d;
            oovf_q  <= oovf_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = clr_n && (state_q == IDLE);
    assign busy      = (state_q == SHIFT) || (state_q == DONE);
    assign out_valid = vld_q;
    assign out_data  = res_q;
    assign out_ovf   = oovf_q;

endmodule

// File: tb/tb_rk_shift_seq.sv
// Scoreboard bench for rk_shift_seq: driver queues expected results, monitor checks on out_valid rise.
module tb_rk_shift_seq;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amt = '0;
    logic        in_dir = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        busy;

    typedef struct {
        logic [31:0] d;
        logic        o;
        int          lat;
        int          t0;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_vld = 1'b0;

`ifdef RK_SHIFT_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_POS = 32'h8000_0000;
`endif

    rk_shift_seq dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: one scoreboard entry per rising out_valid.
    always @(negedge clk) begin
        if (out_valid && !prev_vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", out_data, e.d);
                chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.o});
                chk("latency", cyc - e.t0, e.lat);
            end
        end
        prev_vld <= out_valid;
    end

    task automatic wait_ready();
        @(negedge clk);
        for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
        if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] k, input logic dir,
                        input logic [31:0] ed, input logic eo, input bit push);
        exp_t e;
        wait_ready();
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = k;
        in_dir   = dir;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.d   = ed;
        e.o   = eo;
        e.lat = int'(k) + 1;
        e.t0  = cyc;
        if (push) exp_q.push_back(e);
    endtask

    initial begin
        logic [31:0] held;
        #3;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        send(32'd3,         5'd4,  1'b0, 32'd48,        1'b0, 1'b1);
        send(-32'sd100,     5'd3,  1'b1, -32'sd13,      1'b0, 1'b1);
        send(32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
        send(32'h4000_0000, 5'd1,  1'b0, OVF_POS,       1'b1, 1'b1);
        send(32'h0000_0001, 5'd31, 1'b0, OVF_POS,       1'b1, 1'b1);
        send(-32'sd3,       5'd2,  1'b0, -32'sd12,      1'b0, 1'b1);

        // Back-pressure: result must hold while out_ready is low.
        wait_ready();
        out_ready = 1'b0;
        send(32'd6, 5'd1, 1'b0, 32'd12, 1'b0, 1'b1);
        wait_valid();
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", out_data, held);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset during SHIFT discards the operation.
        send(32'd7, 5'd8, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("shift_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        chk("clr_busy", {31'd0, busy}, 32'd0);
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_out_data", out_data, 32'd0);
        chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        send(32'd5, 5'd1, 1'b0, 32'd10, 1'b0, 1'b1);

        wait_ready();
        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
